// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding req/ack data bus with byte lanes,
// load alignment/extension and a one-cycle writeback pulse. Optional: MEM_MISALIGN_CHECK_EN.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] mem_write_data_i,
  input  logic        reg_write_i,
  input  logic [4:0]  rd_addr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;

  logic        is_store, mem_op, mis_access;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_data;

  // A store wins when both read and write are flagged.
  assign is_store = mem_write_i;
  assign mem_op   = mem_read_i | mem_write_i;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_access = mem_op &
                      (((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                       (funct3_i[1] & (alu_result_i[1:0] != 2'b00)));
`else
  assign mis_access = 1'b0;
`endif

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = mem_write_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        store_be    = 4'b0001 << alu_result_i[1:0];
        store_wdata = {4{mem_write_data_i[7:0]}};
      end
      2'b01: begin
        store_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{mem_write_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane8     = dmem_rdata_i[8*off_q +: 8];
    lane16    = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    load_data = dmem_rdata_i;
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{lane8[7] & ~funct3_q[2]}}, lane8};
      2'b01:   load_data = {{16{lane16[15] & ~funct3_q[2]}}, lane16};
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    misalign_d     = misalign_q;
    unique case (state_q)
      StIdle: begin
        if (ex_valid_i) begin
          wb_rd_d    = rd_addr_i;
          wb_data_d  = alu_result_i;
          misalign_d = 1'b0;
          if (!mem_op) begin
            wb_reg_write_d = reg_write_i;
            state_d        = StDone;
          end else if (mis_access) begin
            wb_reg_write_d = 1'b0;
            misalign_d     = 1'b1;
            state_d        = StDone;
          end else begin
            we_d           = is_store;
            addr_d         = {alu_result_i[31:2], 2'b00};
            be_d           = is_store ? store_be : 4'b1111;
            wdata_d        = is_store ? store_wdata : 32'h0;
            funct3_d       = funct3_i;
            off_d          = alu_result_i[1:0];
            wb_reg_write_d = is_store ? 1'b0 : reg_write_i;
            state_d        = StBus;
          end
        end
      end
      StBus: begin
        if (dmem_ack_i) begin
          if (!we_q) wb_data_d = load_data;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      funct3_q       <= '0;
      off_q          <= '0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      misalign_q     <= misalign_d;
    end
  end

  assign ex_ready_o     = (state_q == StIdle) & ~rst;
  assign dmem_req_o     = (state_q == StBus);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;
  assign wb_valid_o     = (state_q == StDone);
  assign wb_reg_write_o = wb_reg_write_q;
  assign wb_rd_addr_o   = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign misalign_o     = misalign_q & (state_q == StDone);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stimulus pushes expected writebacks into a queue that a
// negedge monitor pops and compares; bus fields are checked while the bench plays memory.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, mem_read_i, mem_write_i, reg_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, mem_write_data_i;
  logic [4:0]  rd_addr_i;
  logic        ex_ready_o, dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, wb_data_o;
  logic [3:0]  dmem_be_o;
  logic        wb_valid_o, wb_reg_write_o, misalign_o;
  logic [4:0]  wb_rd_addr_o;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  mem_access dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .mem_read_i       (mem_read_i),
    .mem_write_i      (mem_write_i),
    .funct3_i         (funct3_i),
    .alu_result_i     (alu_result_i),
    .mem_write_data_i (mem_write_data_i),
    .reg_write_i      (reg_write_i),
    .rd_addr_i        (rd_addr_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_ack_i       (dmem_ack_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_reg_write_o   (wb_reg_write_o),
    .wb_rd_addr_o     (wb_rd_addr_o),
    .wb_data_o        (wb_data_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Writeback monitor
  always @(negedge clk) begin
    if (!rst && wb_valid_o) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid_o), 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_reg_write", 32'(wb_reg_write_o), 32'(e.rw));
        check("wb_rd", 32'(wb_rd_addr_o), 32'(e.rd));
        check("wb_misalign", 32'(misalign_o), 32'(e.mis));
        if (e.chk_data) check("wb_data", wb_data_o, e.data);
      end
    end
  end

  // Issue one instruction at a negedge; act as memory with `waits` extra request cycles.
  task automatic run_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                        input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                        input logic exp_bus, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input wb_t exp_wb);
    check("ex_ready_idle", 32'(ex_ready_o), 32'd1);
    ex_valid_i = 1'b1; mem_read_i = rd_en; mem_write_i = wr_en; funct3_i = f3;
    alu_result_i = addr; mem_write_data_i = wd; reg_write_i = rw; rd_addr_i = rd;
    exp_q.push_back(exp_wb);
    @(negedge clk);
    ex_valid_i = 1'b0;
    if (exp_bus) begin
      for (int k = 0; k <= waits; k++) begin
        check("req_high", 32'(dmem_req_o), 32'd1);
        check("req_we", 32'(dmem_we_o), 32'(wr_en));
        check("req_addr", dmem_addr_o, exp_addr);
        check("req_be", 32'(dmem_be_o), 32'(exp_be));
        if (wr_en) check("req_wdata", dmem_wdata_o, exp_wdata);
        if (k == waits) begin
          dmem_ack_i = 1'b1;
          dmem_rdata_i = rdata;
        end
        @(negedge clk);
        dmem_ack_i = 1'b0;
      end
    end
    check("req_low_at_wb", 32'(dmem_req_o), 32'd0);
    check("wb_valid_pulse", 32'(wb_valid_o), 32'd1);
    check("ex_ready_in_done", 32'(ex_ready_o), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'd0; alu_result_i = '0; mem_write_data_i = '0; reg_write_i = 1'b0;
    rd_addr_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    check("rst_ex_ready", 32'(ex_ready_o), 32'd0);
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_be", 32'(dmem_be_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Non-memory pass-through
    run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 1, 5'd5, 32'h0, 0,
           0, 32'h0, 4'h0, 32'h0, '{1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0});
    // SB 0x103 with three wait cycles
    run_op(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 1, 5'd3, 32'h0, 3,
           1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, '{1'b0, 5'd3, 32'h0, 1'b0, 1'b0});
    // LB / LBU lane 2
    run_op(1, 0, 3'b000, 32'h0000_0202, 32'h0, 1, 5'd7, 32'h0080_0000, 0,
           1, 32'h0000_0200, 4'b1111, 32'h0, '{1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0});
    run_op(1, 0, 3'b100, 32'h0000_0202, 32'h0, 1, 5'd8, 32'h0080_0000, 1,
           1, 32'h0000_0200, 4'b1111, 32'h0, '{1'b1, 5'd8, 32'h0000_0080, 1'b1, 1'b0});
    // LH upper half, LHU lower half
    run_op(1, 0, 3'b001, 32'h0000_0302, 32'h0, 1, 5'd9, 32'h8001_0000, 0,
           1, 32'h0000_0300, 4'b1111, 32'h0, '{1'b1, 5'd9, 32'hFFFF_8001, 1'b1, 1'b0});
    run_op(1, 0, 3'b101, 32'h0000_0300, 32'h0, 0, 5'd10, 32'h1234_ABCD, 0,
           1, 32'h0000_0300, 4'b1111, 32'h0, '{1'b0, 5'd10, 32'h0000_ABCD, 1'b1, 1'b0});
    // SH upper half, SW
    run_op(0, 1, 3'b001, 32'h0000_0102, 32'h0000_5678, 1, 5'd11, 32'h0, 0,
           1, 32'h0000_0100, 4'b1100, 32'h5678_5678, '{1'b0, 5'd11, 32'h0, 1'b0, 1'b0});
    run_op(0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1, 5'd12, 32'h0, 1,
           1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, '{1'b0, 5'd12, 32'h0, 1'b0, 1'b0});
    // Read and write both set: store wins
    run_op(1, 1, 3'b000, 32'h0000_0001, 32'h0000_0011, 1, 5'd13, 32'hFFFF_FFFF, 0,
           1, 32'h0000_0000, 4'b0010, 32'h1111_1111, '{1'b0, 5'd13, 32'h0, 1'b0, 1'b0});
`ifdef MEM_MISALIGN_CHECK_EN
    run_op(1, 0, 3'b010, 32'h0000_0401, 32'h0, 1, 5'd14, 32'h0, 0,
           0, 32'h0, 4'h0, 32'h0, '{1'b0, 5'd14, 32'h0, 1'b0, 1'b1});
`else
    run_op(1, 0, 3'b010, 32'h0000_0401, 32'h0, 1, 5'd14, 32'hCAFE_F00D, 0,
           1, 32'h0000_0400, 4'b1111, 32'h0, '{1'b1, 5'd14, 32'hCAFE_F00D, 1'b1, 1'b0});
`endif

    // Reset while a load waits on the bus, then a late ack
    check("ex_ready_pre_rst_op", 32'(ex_ready_o), 32'd1);
    ex_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
    alu_result_i = 32'h0000_0500; reg_write_i = 1'b1; rd_addr_i = 5'd15;
    @(negedge clk);
    ex_valid_i = 1'b0;
    check("rst_bus_req", 32'(dmem_req_o), 32'd1);
    rst = 1'b1;
    #1 check("ex_ready_in_rst", 32'(ex_ready_o), 32'd0);
    @(negedge clk);
    check("req_drop_at_rst", 32'(dmem_req_o), 32'd0);
    rst = 1'b0;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h5555_5555;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    check("late_ack_no_wb", 32'(wb_valid_o), 32'd0);
    check("late_ack_no_req", 32'(dmem_req_o), 32'd0);
    check("ex_ready_after_rst", 32'(ex_ready_o), 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline; the consumer of the execute stage's ALU result and store data. It accepts one instruction per handshake and passes non-memory instructions through in one cycle. For loads and stores it drives a single-outstanding req/ack data-memory bus with byte enables, then aligns and sign- or zero-extends load data. It emits a one-cycle writeback pulse to the register-file stage.

## Interface
- No parameters. Widths: RegBus = 32, register address = 5.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_valid_i  in  1  execute stage presents an instruction.
- ex_ready_o  out  1  stage can accept; the instruction transfers when ex_valid_i and ex_ready_o are both high.
- mem_read_i  in  1  instruction is a load.
- mem_write_i  in  1  instruction is a store.
- funct3_i  in  3  RISC-V width/sign field.
- alu_result_i  in  32  effective address, or the result for non-memory instructions.
- mem_write_data_i  in  32  store data (rs2).
- reg_write_i  in  1  instruction writes rd.
- rd_addr_i  in  5  destination register.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address; bits [1:0] always 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-aligned write data.
- dmem_ack_i  in  1  bus completion; rdata valid in the same cycle.
- dmem_rdata_i  in  32  read word.
- wb_valid_o  out  1  writeback pulse, one cycle.
- wb_reg_write_o  out  1  write rd.
- wb_rd_addr_o  out  5  rd.
- wb_data_o  out  32  result.
- misalign_o  out  1  misaligned-access pulse, coincident with wb_valid_o.

## Operation
- States: IDLE, BUS, DONE.
- ex_ready_o is 1 only in IDLE and not in reset.
- IDLE, accept, no memory op → DONE with wb_data = alu_result_i.
- IDLE, accept, memory op → BUS. The request fields are latched at accept.
- If mem_read_i and mem_write_i are both 1, the store takes precedence.
- BUS: dmem_req_o = 1 and all request outputs are held constant until dmem_ack_i. On ack → DONE; load data is captured from dmem_rdata_i in that cycle.
- DONE: wb_valid_o = 1 for exactly one cycle, then IDLE.
- Stores write back with wb_reg_write_o = 0.
- Loads write back with wb_reg_write_o = latched reg_write_i.
- Lane offset is off = addr[1:0].
- Width is selected by funct3[1:0]: 00 = byte, 01 = half, other = word.
- Store byte: be = 0001<<off; wdata = byte replicated ×4.
- Store half: be = 0011 when addr[1]=0, else 1100; wdata = half replicated ×2.
- Store word: be = 1111; wdata = data.
- Load byte: select lane off. Load half: select bytes [2·addr[1]+1 : 2·addr[1]]. Load word: full word.
- Load extension: funct3[2] = 1 zero-extends, else sign-extends.
- Loads drive be = 1111.
- dmem_ack_i outside BUS is ignored.
- No backpressure from writeback.

## Timing
- Reset: state IDLE.
- Reset values: all outputs 0, including dmem_req_o, wb_valid_o and misalign_o.
- ex_ready_o reads 0 while rst = 1 and 1 in the first cycle after reset.
- Non-memory op accepted at edge N: wb_valid_o is high in cycle N+1 and ex_ready_o is high again in N+2.
- Memory op accepted at edge N: dmem_req_o is high from cycle N+1. With ack sampled at edge M, wb_valid_o is high in cycle M+1 and dmem_req_o is low in M+1.
- Minimum memory latency: accept → writeback = 2 cycles, with ack in the first request cycle.
- Throughput: one non-memory instruction per 2 cycles.
- Reset mid-BUS: the request is abandoned and dmem_req_o drops at the reset edge. A late ack after reset is ignored.

## Configuration
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined: these accesses are misaligned:
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 00.
  A misaligned access issues no bus request and goes IDLE → DONE. In DONE: wb_valid_o = 1, misalign_o = 1, wb_reg_write_o = 0.
- Undefined: misalign_o is tied 0 and accesses always proceed.
  - Half ignores addr[0].
  - Word ignores addr[1:0] and uses be = 1111.

## Test plan
- Non-memory op: alu_result_i = 0x1234_5678, rd = 5, reg_write = 1 → next cycle wb_valid_o = 1, wb_data_o = 0x1234_5678, wb_rd_addr_o = 5, dmem_req_o never 1.
- SB, addr 0x103, data 0xAB: ack after 3 wait cycles → dmem_addr_o = 0x100, be = 1000, wdata = 0xABAB_ABAB held stable for 4 cycles; wb_reg_write_o = 0.
- LB/LBU, addr 0x202, rdata 0x0080_0000 → LB gives wb_data_o = 0xFFFF_FF80; LBU gives 0x0000_0080.
- LH, addr 0x302, rdata 0x8001_0000 → wb_data_o = 0xFFFF_8001, be = 1111.
- LW, addr 0x401, with MEM_MISALIGN_CHECK_EN → no dmem_req_o; wb_valid_o = misalign_o = 1 in cycle N+1; wb_reg_write_o = 0.
- Reset while in BUS, then ack one cycle later → dmem_req_o low, wb_valid_o stays 0, ex_ready_o = 1 after reset.
